core_if_prefetch: RTL

Parametrised instruction-fetch front end combining PC generation, ROM request issue and an instruction prefetch queue. It replaces the single-instruction PC/IF/IF-ID path of the xrv32i core. It sits between instruction memory and `core_id`. It keeps up to DEPTH fetches in flight or buffered, so the decoder sees one instruction per cycle despite memory latency. It flushes cleanly on jumps.

---
 rtl/core_if_prefetch_pkg.sv | 12 +
 rtl/core_if_prefetch_if.sv | 40 ++++
 rtl/core_sync_fifo.sv | 55 +++++
 rtl/core_if_prefetch.sv | 100 ++++++++++
 4 files changed

// File: rtl/core_if_prefetch_pkg.sv
// Shared bus widths and fetch defaults for the instruction-fetch front end.
package core_if_prefetch_pkg;
  localparam int INST_BUS_W       = 32;
  localparam int MEM_ADDR_BUS_W   = 32;
  localparam logic [MEM_ADDR_BUS_W-1:0] RESET_PC_DEFAULT = '0;
  localparam int PC_STEP_DEFAULT  = 4;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/core_if_prefetch_if.sv
// Fetch front-end bundle: redirect/hold controls, ROM request/response, decode handshake.
interface core_if_prefetch_if
  import core_if_prefetch_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_BUS_W,
  parameter int INST_W = INST_BUS_W,
  parameter int DEPTH  = 4
) ();
  localparam int LVL_W = level_width(DEPTH);

  logic              jump_flag_in;
  logic [ADDR_W-1:0] jump_addr_in;
  logic              hold_flag_in;
  logic              rom_req_valid_out;
  logic              rom_req_ready_in;
  logic [ADDR_W-1:0] rom_addr_out;
  logic              rom_rsp_valid_in;
  logic [INST_W-1:0] rom_rsp_data_in;
  logic              inst_valid_out;
  logic              inst_ready_in;
  logic [INST_W-1:0] inst_out;
  logic [ADDR_W-1:0] inst_addr_out;
  logic [LVL_W-1:0]  level_out;

  modport master (
    input  jump_flag_in, jump_addr_in, hold_flag_in,
    output rom_req_valid_out, rom_addr_out,
    input  rom_req_ready_in, rom_rsp_valid_in, rom_rsp_data_in,
    output inst_valid_out, inst_out, inst_addr_out, level_out,
    input  inst_ready_in
  );

  modport slave (
    output jump_flag_in, jump_addr_in, hold_flag_in,
    input  rom_req_valid_out, rom_addr_out,
    output rom_req_ready_in, rom_rsp_valid_in, rom_rsp_data_in,
    input  inst_valid_out, inst_out, inst_addr_out, level_out,
    output inst_ready_in
  );
endinterface

// File: rtl/core_sync_fifo.sv
// Generic synchronous FIFO; flush empties it in one cycle.
// Latency: pushed word is at the head the cycle after the push.
// Backpressure: push while full and pop while empty are ignored; full/empty exposed to the caller.
module core_sync_fifo
  import core_if_prefetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_dat,
  input  logic                          pop,
  input  logic                          flush,
  output logic [WIDTH-1:0]              head_dat,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          full,
  output logic                          empty
);
  localparam int LVL_W = level_width(DEPTH);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LVL_W-1:0] count;
  logic             push_ok, pop_ok;

  assign full     = (count == LVL_W'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign head_dat = mem[rd_ptr];
  assign level    = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + LVL_W'(push_ok) - LVL_W'(pop_ok);
    end
  end
endmodule

// File: rtl/core_if_prefetch.sv
// Instruction-fetch front end: PC generation, ROM request issue and a prefetch queue.
// Latency: response in cycle N is presented to decode in cycle N+1; jump target requested the next cycle.
// Backpressure: requests stop once in-flight plus queued reaches DEPTH; hold blocks issue only.
module core_if_prefetch
  import core_if_prefetch_pkg::*;
#(
  parameter int                ADDR_W   = MEM_ADDR_BUS_W,
  parameter int                INST_W   = INST_BUS_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
  parameter int                PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  core_if_prefetch_if.master bus
);
  localparam int LVL_W = level_width(DEPTH);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  logic [ADDR_W-1:0]        fetch_pc, rsp_pc;
  logic [LVL_W-1:0]         outstanding, discard, level;
  logic [LVL_W:0]           credit_used;
  logic                     full, empty;
  logic                     req_vld, req_fire, rsp_fire, keep_rsp, drop_rsp;
  logic                     push, pop, flush, inst_vld;
  entry_t                   push_entry, head;
  logic [$bits(entry_t)-1:0] head_vec;

  always_comb begin
    credit_used = {1'b0, outstanding} + {1'b0, level};
    req_vld  = !rst && !bus.jump_flag_in && !bus.hold_flag_in
               && (credit_used < (LVL_W+1)'(DEPTH));
    req_fire = req_vld && bus.rom_req_ready_in;
    // A response with nothing outstanding is a memory protocol error and is ignored.
    rsp_fire = bus.rom_rsp_valid_in && (outstanding != '0);
    drop_rsp = rsp_fire && (discard != '0);
    keep_rsp = rsp_fire && (discard == '0) && !bus.jump_flag_in;
    inst_vld = !rst && !bus.jump_flag_in && !empty;
    pop      = inst_vld && bus.inst_ready_in;
    push     = keep_rsp;
    flush    = bus.jump_flag_in;
  end

  assign push_entry = '{inst: bus.rom_rsp_data_in, addr: rsp_pc};
  assign head       = head_vec;

  core_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .flush    (flush),
    .head_dat (head_vec),
    .level    (level),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + LVL_W'(req_fire) - LVL_W'(rsp_fire);
      if (bus.jump_flag_in) begin
        fetch_pc <= bus.jump_addr_in;
        rsp_pc   <= bus.jump_addr_in;
        // Stale responses already counted in discard are also in outstanding,
        // so every request still unanswered after this cycle becomes stale.
        discard  <= outstanding - LVL_W'(rsp_fire);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        if (keep_rsp) rsp_pc   <= rsp_pc + ADDR_W'(PC_STEP);
        if (drop_rsp) discard  <= discard - LVL_W'(1);
      end
    end
  end

  assign bus.rom_req_valid_out = req_vld;
  assign bus.rom_addr_out      = fetch_pc;
  assign bus.inst_valid_out    = inst_vld;
  assign bus.inst_out          = head.inst;
  assign bus.inst_addr_out     = head.addr;
  assign bus.level_out         = level;

  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    bus.rom_rsp_valid_in |-> (outstanding != '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    push |-> !full);
endmodule
